// File: rtl/mlaccel_memarb_if.sv
// mlaccel_memarb_if: request/response bundle between the three requesters,
// the memory arbiter and the memory port.
//   host_* : host command path, 16-bit reads (wen == 0) and byte-masked writes
//   seq_*  : sequencer instruction fetch, 32-bit reads only
//   comp_* : compute writeback, 16-bit byte-masked writes only
//   mem_*  : shared single memory port
//   idle   : no request pending and no read in flight
// slave  modport: the arbiter side.
// master modport: requesters plus memory, i.e. the environment around the arbiter.
interface mlaccel_memarb_if;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_wen;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_rvalid;
  logic [15:0] host_rdata;

  logic        seq_valid;
  logic        seq_ready;
  logic [15:0] seq_addr;
  logic        seq_rvalid;
  logic [31:0] seq_rdata;

  logic        comp_valid;
  logic        comp_ready;
  logic [1:0]  comp_wen;
  logic [15:0] comp_addr;
  logic [15:0] comp_wdata;

  logic [15:0] mem_addr;
  logic [1:0]  mem_wen;
  logic [15:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic        idle;

  modport slave (
    input  host_valid, host_wen, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    input  seq_valid, seq_addr,
    output seq_ready, seq_rvalid, seq_rdata,
    input  comp_valid, comp_wen, comp_addr, comp_wdata,
    output comp_ready,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata,
    output idle
  );

  modport master (
    output host_valid, host_wen, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    output seq_valid, seq_addr,
    input  seq_ready, seq_rvalid, seq_rdata,
    output comp_valid, comp_wen, comp_addr, comp_wdata,
    input  comp_ready,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata,
    input  idle
  );
endinterface

// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: three-port arbiter in front of the accelerator memory.
// Shares one memory port between host (r/w), sequencer fetch (r) and compute
// writeback (w). Priority host > comp > seq, except that a low-priority
// requester refused STARVE_MAX cycles in a row is forced ahead of everyone
// (seq first if both are starved). Reads are tracked by an RD_LAT-deep tag
// pipe whose output pulses the issuer's rvalid.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : mlaccel_memarb_if.slave (requester handshakes, memory port, idle)
// Parameters:
//   RD_LAT     : memory read latency, 1..7
//   STARVE_MAX : refusal count that forces a grant, 1..15

// Per-requester starvation counter. Counts consecutive refused cycles while
// valid is held, saturates at STARVE_MAX, clears on acceptance or valid drop.
module mlaccel_memarb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  input  logic accept,
  output logic starved
);
  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !valid || accept) cnt <= '0;
    else if (cnt != 4'(STARVE_MAX)) cnt <= cnt + 4'd1;
  end

  // Gate with valid: a stale saturated count must not grant an empty port.
  assign starved = valid && (cnt == 4'(STARVE_MAX));
endmodule

module mlaccel_memarb #(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  mlaccel_memarb_if.slave  bus
);
  // Lane 0 = seq, lane 1 = comp (the two guarded requesters).
  localparam int NUM_LANES = 2;
  localparam int L_SEQ     = 0;
  localparam int L_COMP    = 1;

  typedef enum logic [1:0] {GNT_NONE, GNT_HOST, GNT_COMP, GNT_SEQ} gnt_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_HOST, TAG_SEQ} tag_e;

  logic [NUM_LANES-1:0] lane_vld, lane_acc, lane_starved;
  gnt_e                 gnt;
  tag_e                 tag_in;
  tag_e                 tag_q [RD_LAT];
  logic                 tag_busy;

  assign lane_vld[L_SEQ]  = bus.seq_valid;
  assign lane_vld[L_COMP] = bus.comp_valid;
  assign lane_acc[L_SEQ]  = (gnt == GNT_SEQ);
  assign lane_acc[L_COMP] = (gnt == GNT_COMP);

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mlaccel_memarb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clock   (clock),
        .reset   (reset),
        .valid   (lane_vld[g]),
        .accept  (lane_acc[g]),
        .starved (lane_starved[g])
      );
    end
  endgenerate

  // Grant: no ready during reset; forced lanes first, then fixed priority.
  always_comb begin
    gnt = GNT_NONE;
    if (reset)                      gnt = GNT_NONE;
    else if (lane_starved[L_SEQ])   gnt = GNT_SEQ;
    else if (lane_starved[L_COMP])  gnt = GNT_COMP;
    else if (bus.host_valid)        gnt = GNT_HOST;
    else if (bus.comp_valid)        gnt = GNT_COMP;
    else if (bus.seq_valid)         gnt = GNT_SEQ;
  end

  assign bus.host_ready = (gnt == GNT_HOST);
  assign bus.comp_ready = (gnt == GNT_COMP);
  assign bus.seq_ready  = (gnt == GNT_SEQ);

  // Memory port mux; all-zero when nothing is granted.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wen   = '0;
    bus.mem_wdata = '0;
    tag_in        = TAG_NONE;
    case (gnt)
      GNT_HOST: begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wen   = bus.host_wen;
        bus.mem_wdata = bus.host_wdata;
        if (bus.host_wen == 2'b00) tag_in = TAG_HOST;
      end
      GNT_COMP: begin
        // comp_wen == 0 is a protocol error; it passes through as a no-op access.
        bus.mem_addr  = bus.comp_addr;
        bus.mem_wen   = bus.comp_wen;
        bus.mem_wdata = bus.comp_wdata;
      end
      GNT_SEQ: begin
        bus.mem_addr  = bus.seq_addr;
        tag_in        = TAG_SEQ;
      end
      default: ;
    endcase
  end

  // Read tag pipe: stage RD_LAT-1 lines up with mem_rdata for that read.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++)
      if (tag_q[i] != TAG_NONE) tag_busy = 1'b1;
  end

  assign bus.host_rvalid = (tag_q[RD_LAT-1] == TAG_HOST);
  assign bus.seq_rvalid  = (tag_q[RD_LAT-1] == TAG_SEQ);
  assign bus.host_rdata  = bus.mem_rdata[15:0];
  assign bus.seq_rdata   = bus.mem_rdata[31:0];

  assign bus.idle = !bus.host_valid && !bus.seq_valid && !bus.comp_valid && !tag_busy;
endmodule

// File: tb/tb_mlaccel_memarb.sv
// tb_mlaccel_memarb: directed self-checking bench for mlaccel_memarb with a
// behavioural RD_LAT-latency memory returning four consecutive words.
module tb_mlaccel_memarb;
  localparam int RD_LAT = 2;
  localparam logic [2:0] H = 3'b100, C = 3'b010, S = 3'b001;

  logic clock = 1'b0;
  logic reset;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  mlaccel_memarb_if bus();

  mlaccel_memarb #(.RD_LAT(RD_LAT), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory model with a preload port so only one process writes the array.
  logic [15:0] mem [0:65535];
  logic [63:0] rd_pipe [RD_LAT];
  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else begin
      if (bus.mem_wen[0]) mem[bus.mem_addr][7:0]  <= bus.mem_wdata[7:0];
      if (bus.mem_wen[1]) mem[bus.mem_addr][15:8] <= bus.mem_wdata[15:8];
    end
    rd_pipe[0] <= {mem[bus.mem_addr + 16'd3], mem[bus.mem_addr + 16'd2],
                   mem[bus.mem_addr + 16'd1], mem[bus.mem_addr]};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  exp_ord [12];
  logic [31:0] exp_seq [4];

  initial begin
    exp_ord = '{H, H, H, H, S, C, H, H, H, S, C, H};
    exp_seq = '{32'h2222_1111, 32'h3333_2222, 32'h4444_3333, 32'h5555_4444};
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.host_valid = 1'b1; bus.host_wen = '0; bus.host_addr = 16'h0010; bus.host_wdata = '0;
    bus.seq_valid = 1'b0; bus.seq_addr = '0;
    bus.comp_valid = 1'b0; bus.comp_wen = '0; bus.comp_addr = '0; bus.comp_wdata = '0;

    // Reset: no ready even with a valid pending.
    @(negedge clock);
    chk("reset_host_ready", bus.host_ready, 1'b0);
    step();
    bus.host_valid = 1'b0;
    preload(16'h0010, 16'hBEEF);
    preload(16'h0100, 16'h1111);
    preload(16'h0101, 16'h2222);
    preload(16'h0102, 16'h3333);
    preload(16'h0103, 16'h4444);
    preload(16'h0104, 16'h5555);
    preload(16'h0030, 16'h5566);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_host_rvalid", bus.host_rvalid, 1'b0);
    chk("reset_seq_rvalid", bus.seq_rvalid, 1'b0);
    chk("reset_idle", bus.idle, 1'b1);
    chk("nogrant_mem_wen", bus.mem_wen, 2'b00);
    step();

    // Lone host read, latency RD_LAT.
    bus.host_valid = 1'b1; bus.host_wen = 2'b00; bus.host_addr = 16'h0010;
    @(negedge clock);
    chk("t1_ready", bus.host_ready, 1'b1);
    chk("t1_idle_busy", bus.idle, 1'b0);
    step();
    bus.host_valid = 1'b0;
    @(negedge clock);
    chk("t1_rvalid_n1", bus.host_rvalid, 1'b0);
    step();
    @(negedge clock);
    chk("t1_rvalid_n2", bus.host_rvalid, 1'b1);
    chk("t1_rdata", bus.host_rdata, 16'hBEEF);
    step();
    @(negedge clock);
    chk("t1_rvalid_n3", bus.host_rvalid, 1'b0);
    chk("t1_idle", bus.idle, 1'b1);
    step();

    // Three-way contention with starvation guard.
    bus.host_valid = 1'b1; bus.host_wen = 2'b00; bus.host_addr = 16'h0400;
    bus.comp_valid = 1'b1; bus.comp_wen = 2'b11; bus.comp_addr = 16'h0200; bus.comp_wdata = 16'h7777;
    bus.seq_valid  = 1'b1; bus.seq_addr = 16'h0300;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk($sformatf("arb_order_%0d", k), {bus.host_ready, bus.comp_ready, bus.seq_ready}, exp_ord[k]);
      step();
    end
    bus.host_valid = 1'b0; bus.comp_valid = 1'b0; bus.seq_valid = 1'b0;
    repeat (RD_LAT + 2) step();

    // Back-to-back seq fetches.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin bus.seq_valid = 1'b1; bus.seq_addr = 16'h0100 + 16'(k); end
      else bus.seq_valid = 1'b0;
      @(negedge clock);
      if (k < 4) chk($sformatf("seq_ready_%0d", k), bus.seq_ready, 1'b1);
      chk($sformatf("seq_rvalid_%0d", k), bus.seq_rvalid, (k >= 2) ? 1'b1 : 1'b0);
      if (k >= 2) chk($sformatf("seq_rdata_%0d", k), bus.seq_rdata, exp_seq[k-2]);
      step();
    end
    @(negedge clock);
    chk("seq_rvalid_end", bus.seq_rvalid, 1'b0);
    step();

    // comp write then host read next cycle.
    bus.comp_valid = 1'b1; bus.comp_wen = 2'b11; bus.comp_addr = 16'h0020; bus.comp_wdata = 16'h1234;
    @(negedge clock);
    chk("t4_comp_ready", bus.comp_ready, 1'b1);
    step();
    bus.comp_valid = 1'b0;
    bus.host_valid = 1'b1; bus.host_wen = 2'b00; bus.host_addr = 16'h0020;
    @(negedge clock);
    chk("t4_host_ready", bus.host_ready, 1'b1);
    step();
    bus.host_valid = 1'b0;
    @(negedge clock);
    chk("t4_rvalid_n2", bus.host_rvalid, 1'b0);
    step();
    @(negedge clock);
    chk("t4_rvalid_n3", bus.host_rvalid, 1'b1);
    chk("t4_rdata", bus.host_rdata, 16'h1234);
    step();

    // Reset kills an in-flight read.
    bus.host_valid = 1'b1; bus.host_wen = 2'b00; bus.host_addr = 16'h0010;
    @(negedge clock);
    chk("t5_ready", bus.host_ready, 1'b1);
    step();
    bus.host_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("t5_rvalid_n2", bus.host_rvalid, 1'b0);
    step();
    @(negedge clock);
    chk("t5_rvalid_n3", bus.host_rvalid, 1'b0);
    chk("t5_idle", bus.idle, 1'b1);
    chk("t5_mem_addr_idle", bus.mem_addr, 16'h0000);
    step();

    // Partial write, then a comp access with wen == 0 that must not write.
    bus.host_valid = 1'b1; bus.host_wen = 2'b01; bus.host_addr = 16'h0030; bus.host_wdata = 16'h12AA;
    @(negedge clock);
    chk("t6_wr_ready", bus.host_ready, 1'b1);
    step();
    bus.host_valid = 1'b0;
    bus.comp_valid = 1'b1; bus.comp_wen = 2'b00; bus.comp_addr = 16'h0030; bus.comp_wdata = 16'hFFFF;
    @(negedge clock);
    chk("t6_comp0_ready", bus.comp_ready, 1'b1);
    chk("t6_comp0_mem_wen", bus.mem_wen, 2'b00);
    chk("t6_comp0_mem_addr", bus.mem_addr, 16'h0030);
    step();
    bus.comp_valid = 1'b0;
    bus.host_valid = 1'b1; bus.host_wen = 2'b00; bus.host_addr = 16'h0030;
    @(negedge clock);
    chk("t6_rd_ready", bus.host_ready, 1'b1);
    step();
    bus.host_valid = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock);
    chk("t6_rvalid", bus.host_rvalid, 1'b1);
    chk("t6_rdata", bus.host_rdata, 16'h55AA);
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
